// File: rtl/addsub_rr_arbiter.sv
// Round-robin arbiter that shares one 4-bit adder/subtractor between two requesters.
// Operands are held in registers for SETTLE_CYCLES before the result is captured.
module addsub4 (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       sel,
    output logic [3:0] s,
    output logic       cout
);
    logic [3:0] b_eff;

    always_comb begin
        b_eff     = sel ? ~b : b;
        {cout, s} = {1'b0, a} + {1'b0, b_eff} + {4'b0000, sel};
    end
endmodule

module addsub_rr_arbiter #(
    parameter int unsigned SETTLE_CYCLES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req_valid_0,
    output logic       req_ready_0,
    input  logic [3:0] A_0,
    input  logic [3:0] B_0,
    input  logic       sel_0,
    input  logic       req_valid_1,
    output logic       req_ready_1,
    input  logic [3:0] A_1,
    input  logic [3:0] B_1,
    input  logic       sel_1,
    output logic       rsp_valid_0,
    input  logic       rsp_ready_0,
    output logic       rsp_valid_1,
    input  logic       rsp_ready_1,
    output logic [3:0] S,
    output logic       cout,
    output logic       ovf,
    output logic       busy
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t     state_q, state_d;
    logic       last_grant_q, last_grant_d;
    logic       gnt_q, gnt_d;
    logic [3:0] op_a_q, op_a_d;
    logic [3:0] op_b_q, op_b_d;
    logic       op_sel_q, op_sel_d;
    logic [3:0] cnt_q, cnt_d;
    logic [3:0] s_q, s_d;
    logic       cout_q, cout_d;
    logic       ovf_q, ovf_d;

    logic       grant;
    logic       grant_valid;
    logic [3:0] dp_s;
    logic       dp_cout;
    logic [3:0] b_eff;
    logic       rsp_ready_g;

    addsub4 u_addsub4 (
        .a    (op_a_q),
        .b    (op_b_q),
        .sel  (op_sel_q),
        .s    (dp_s),
        .cout (dp_cout)
    );

    always_comb begin
        grant_valid = req_valid_0 | req_valid_1;
        if (req_valid_0 && req_valid_1) begin
            grant = ~last_grant_q;
        end else begin
            grant = req_valid_1;
        end
    end

    // Ready is gated by rst so nothing reads as accepted while reset is held.
    always_comb begin
        req_ready_0 = (state_q == IDLE) && !rst && grant_valid && !grant;
        req_ready_1 = (state_q == IDLE) && !rst && grant_valid && grant;
        rsp_valid_0 = (state_q == RESP) && !gnt_q;
        rsp_valid_1 = (state_q == RESP) && gnt_q;
        busy        = (state_q != IDLE);
        S           = s_q;
        cout        = cout_q;
        ovf         = ovf_q;
        b_eff       = op_sel_q ? ~op_b_q : op_b_q;
        rsp_ready_g = gnt_q ? rsp_ready_1 : rsp_ready_0;
    end

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        gnt_d        = gnt_q;
        op_a_d       = op_a_q;
        op_b_d       = op_b_q;
        op_sel_d     = op_sel_q;
        cnt_d        = cnt_q;
        s_d          = s_q;
        cout_d       = cout_q;
        ovf_d        = ovf_q;
        unique case (state_q)
            IDLE: begin
                if (grant_valid) begin
                    gnt_d    = grant;
                    op_a_d   = grant ? A_1 : A_0;
                    op_b_d   = grant ? B_1 : B_0;
                    op_sel_d = grant ? sel_1 : sel_0;
                    cnt_d    = 4'(SETTLE_CYCLES - 1);
                    state_d  = EXEC;
                end
            end
            EXEC: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    s_d     = dp_s;
                    cout_d  = dp_cout;
                    ovf_d   = (op_a_q[3] == b_eff[3]) && (dp_s[3] != op_a_q[3]);
                    state_d = RESP;
                end
            end
            RESP: begin
                if (rsp_ready_g) begin
                    last_grant_d = gnt_q;
                    state_d      = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            last_grant_q <= 1'b1;
            gnt_q        <= 1'b0;
            op_a_q       <= '0;
            op_b_q       <= '0;
            op_sel_q     <= 1'b0;
            cnt_q        <= '0;
            s_q          <= '0;
            cout_q       <= 1'b0;
            ovf_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            gnt_q        <= gnt_d;
            op_a_q       <= op_a_d;
            op_b_q       <= op_b_d;
            op_sel_q     <= op_sel_d;
            cnt_q        <= cnt_d;
            s_q          <= s_d;
            cout_q       <= cout_d;
            ovf_q        <= ovf_d;
        end
    end
endmodule

// File: tb/tb_addsub_rr_arbiter.sv
// Directed bench for addsub_rr_arbiter: hand-computed results, grant order,
// response hold and reset-during-execution behaviour.
module tb_addsub_rr_arbiter;
    logic       clk = 1'b0;
    logic       rst;
    logic       req_valid_0, req_ready_0, sel_0;
    logic [3:0] A_0, B_0;
    logic       req_valid_1, req_ready_1, sel_1;
    logic [3:0] A_1, B_1;
    logic       rsp_valid_0, rsp_ready_0, rsp_valid_1, rsp_ready_1;
    logic [3:0] S;
    logic       cout, ovf, busy;

    int pass_cnt  = 0;
    int total_cnt = 0;

    addsub_rr_arbiter #(.SETTLE_CYCLES(2)) dut (
        .clk(clk), .rst(rst),
        .req_valid_0(req_valid_0), .req_ready_0(req_ready_0),
        .A_0(A_0), .B_0(B_0), .sel_0(sel_0),
        .req_valid_1(req_valid_1), .req_ready_1(req_ready_1),
        .A_1(A_1), .B_1(B_1), .sel_1(sel_1),
        .rsp_valid_0(rsp_valid_0), .rsp_ready_0(rsp_ready_0),
        .rsp_valid_1(rsp_valid_1), .rsp_ready_1(rsp_ready_1),
        .S(S), .cout(cout), .ovf(ovf), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        req_valid_0 = 1'b1; req_valid_1 = 1'b0;
        A_0 = 4'd0; B_0 = 4'd0; sel_0 = 1'b0;
        A_1 = 4'd0; B_1 = 4'd0; sel_1 = 1'b0;
        rsp_ready_0 = 1'b0; rsp_ready_1 = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        total_cnt++;
        if ({S, cout, ovf, busy, rsp_valid_0, rsp_valid_1, req_ready_0, req_ready_1} !== 11'd0) begin
            $display("FAIL reset_outputs: got %b expected all zero",
                     {S, cout, ovf, busy, rsp_valid_0, rsp_valid_1, req_ready_0, req_ready_1});
        end else pass_cnt++;
        rst = 1'b0;
        req_valid_0 = 1'b0;
        #1;
    endtask

    // One complete transaction on requester p with the expected result supplied by the caller.
    task automatic run_op(input bit p, input logic [3:0] a, input logic [3:0] b, input logic sl,
                          input logic [3:0] es, input logic ec, input logic eo, input string nm);
        int n;
        if (p) begin A_1 = a; B_1 = b; sel_1 = sl; req_valid_1 = 1'b1; end
        else   begin A_0 = a; B_0 = b; sel_0 = sl; req_valid_0 = 1'b1; end
        #1;
        total_cnt++;
        if ((p ? req_ready_1 : req_ready_0) !== 1'b1) begin
            $display("FAIL %s_ready: got %b expected 1", nm, p ? req_ready_1 : req_ready_0);
        end else pass_cnt++;
        @(posedge clk); #1;
        req_valid_0 = 1'b0; req_valid_1 = 1'b0;
        n = 0;
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk); #1;
            if ((p ? rsp_valid_1 : rsp_valid_0) === 1'b1) begin n = i; break; end
        end
        total_cnt++;
        if (n != 2) begin
            $display("FAIL %s_latency: got %0d edges expected 2", nm, n);
        end else pass_cnt++;
        total_cnt++;
        if ({S, cout, ovf} !== {es, ec, eo}) begin
            $display("FAIL %s_result: got S=%b cout=%b ovf=%b expected S=%b cout=%b ovf=%b",
                     nm, S, cout, ovf, es, ec, eo);
        end else pass_cnt++;
        if (p) rsp_ready_1 = 1'b1; else rsp_ready_0 = 1'b1;
        @(posedge clk); #1;
        rsp_ready_0 = 1'b0; rsp_ready_1 = 1'b0;
        total_cnt++;
        if ({busy, rsp_valid_0, rsp_valid_1} !== 3'b000) begin
            $display("FAIL %s_release: got busy/rv0/rv1=%b expected 000", nm, {busy, rsp_valid_0, rsp_valid_1});
        end else pass_cnt++;
    endtask

    task automatic test_basic();
        run_op(1'b0, 4'd2, 4'd3, 1'b0, 4'b0101, 1'b0, 1'b0, "add_2_3");
        run_op(1'b1, 4'd5, 4'd2, 1'b1, 4'b0011, 1'b1, 1'b0, "sub_5_2");
        run_op(1'b1, 4'd2, 4'd5, 1'b1, 4'b1101, 1'b0, 1'b0, "sub_2_5");
    endtask

    task automatic test_overflow();
        run_op(1'b0, 4'd5,     4'd6,     1'b0, 4'b1011, 1'b0, 1'b1, "ovf_5_6");
        run_op(1'b0, 4'd10,    4'd12,    1'b0, 4'b0110, 1'b1, 1'b1, "ovf_10_12");
        run_op(1'b0, 4'b1011,  4'b1110,  1'b1, 4'b1101, 1'b0, 1'b0, "sub_m5_m2");
    endtask

    task automatic test_round_robin();
        int got [4];
        int ng;
        bit overlap;
        do_reset();
        A_0 = 4'd3; B_0 = 4'd4; sel_0 = 1'b0;
        A_1 = 4'd7; B_1 = 4'd1; sel_1 = 1'b1;
        req_valid_0 = 1'b1; req_valid_1 = 1'b1;
        rsp_ready_0 = 1'b1; rsp_ready_1 = 1'b1;
        #1;
        total_cnt++;
        if ({req_ready_0, req_ready_1} !== 2'b10) begin
            $display("FAIL rr_first_tie: got ready0/1=%b expected 10", {req_ready_0, req_ready_1});
        end else pass_cnt++;
        ng = 0;
        overlap = 1'b0;
        for (int i = 0; i < 100 && ng < 4; i++) begin
            @(posedge clk); #1;
            if (rsp_valid_0 && rsp_valid_1) overlap = 1'b1;
            if (rsp_valid_0 || rsp_valid_1) begin
                got[ng] = rsp_valid_1 ? 1 : 0;
                total_cnt++;
                if (rsp_valid_1 ? ({S, cout, ovf} !== {4'b0110, 1'b1, 1'b0})
                                : ({S, cout, ovf} !== {4'b0111, 1'b0, 1'b0})) begin
                    $display("FAIL rr_result_%0d: got S=%b cout=%b ovf=%b for requester %0d",
                             ng, S, cout, ovf, got[ng]);
                end else pass_cnt++;
                ng++;
            end
        end
        req_valid_0 = 1'b0; req_valid_1 = 1'b0;
        total_cnt++;
        if (ng != 4 || got[0] != 0 || got[1] != 1 || got[2] != 0 || got[3] != 1) begin
            $display("FAIL rr_order: got %0d responses order %0d%0d%0d%0d expected 4 responses order 0101",
                     ng, got[0], got[1], got[2], got[3]);
        end else pass_cnt++;
        total_cnt++;
        if (overlap) begin
            $display("FAIL rr_overlap: got both rsp_valid high expected never");
        end else pass_cnt++;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rsp_ready_0 = 1'b0; rsp_ready_1 = 1'b0;
        total_cnt++;
        if (busy !== 1'b0) begin
            $display("FAIL rr_idle: got busy=%b expected 0", busy);
        end else pass_cnt++;
    endtask

    task automatic test_resp_hold();
        int n;
        bit bad;
        A_0 = 4'd1; B_0 = 4'd1; sel_0 = 1'b0; req_valid_0 = 1'b1;
        rsp_ready_0 = 1'b0; rsp_ready_1 = 1'b1;
        @(posedge clk); #1;
        req_valid_0 = 1'b0;
        A_1 = 4'd6; B_1 = 4'd3; sel_1 = 1'b1; req_valid_1 = 1'b1;
        n = 0;
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk); #1;
            if (rsp_valid_0 === 1'b1) begin n = i; break; end
        end
        total_cnt++;
        if (n != 2) begin
            $display("FAIL hold_latency: got %0d edges expected 2", n);
        end else pass_cnt++;
        bad = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            if ({S, cout, ovf, req_ready_1, busy, rsp_valid_0, rsp_valid_1} !== {4'b0010, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0})
                bad = 1'b1;
        end
        total_cnt++;
        if (bad) begin
            $display("FAIL hold_stable: got S=%b cout=%b ovf=%b rdy1=%b busy=%b rv=%b%b expected 0010 0 0 0 1 10",
                     S, cout, ovf, req_ready_1, busy, rsp_valid_0, rsp_valid_1);
        end else pass_cnt++;
        rsp_ready_0 = 1'b1;
        @(posedge clk); #1;
        rsp_ready_0 = 1'b0; rsp_ready_1 = 1'b0;
        total_cnt++;
        if ({busy, req_ready_1} !== 2'b01) begin
            $display("FAIL hold_release: got busy/rdy1=%b expected 01", {busy, req_ready_1});
        end else pass_cnt++;
        @(posedge clk); #1;
        req_valid_1 = 1'b0;
        n = 0;
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk); #1;
            if (rsp_valid_1 === 1'b1) begin n = i; break; end
        end
        total_cnt++;
        if (n != 2 || {S, cout, ovf} !== {4'b0011, 1'b1, 1'b0}) begin
            $display("FAIL hold_next_req1: got edges=%0d S=%b cout=%b ovf=%b expected 2 0011 1 0",
                     n, S, cout, ovf);
        end else pass_cnt++;
        rsp_ready_1 = 1'b1;
        @(posedge clk); #1;
        rsp_ready_1 = 1'b0;
    endtask

    task automatic test_reset_exec();
        bit seen;
        A_0 = 4'd4; B_0 = 4'd4; sel_0 = 1'b0; req_valid_0 = 1'b1;
        @(posedge clk); #1;
        req_valid_0 = 1'b0;
        total_cnt++;
        if (busy !== 1'b1) begin
            $display("FAIL rexec_busy: got busy=%b expected 1", busy);
        end else pass_cnt++;
        rst = 1'b1;
        #1;
        total_cnt++;
        if ({S, cout, ovf, busy, rsp_valid_0, rsp_valid_1} !== 9'd0) begin
            $display("FAIL rexec_clear: got %b expected all zero", {S, cout, ovf, busy, rsp_valid_0, rsp_valid_1});
        end else pass_cnt++;
        @(posedge clk); #1;
        rst = 1'b0;
        rsp_ready_0 = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            if (rsp_valid_0 || rsp_valid_1 || busy) seen = 1'b1;
        end
        rsp_ready_0 = 1'b0;
        total_cnt++;
        if (seen) begin
            $display("FAIL rexec_dropped: got activity after reset expected none");
        end else pass_cnt++;
        run_op(1'b0, 4'd2, 4'd3, 1'b0, 4'b0101, 1'b0, 1'b0, "after_rst");
    endtask

    initial begin
        test_reset();
        test_basic();
        test_overflow();
        test_round_robin();
        test_resp_hold();
        test_reset_exec();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule

// File: doc/addsub_rr_arbiter.md
Name: addsub_rr_arbiter

Overview:
Arbiter and sequencer that shares one 4-bit adder/subtractor datapath (A, B, sel → S, cout) between two requesters.
- Accepts one operation at a time through a valid/ready handshake, using round-robin priority.
- Holds the operands stable for a programmable settle time so that gate-delay variants of the datapath resolve before sampling.
- Returns a registered result (S, cout, signed overflow) to the granted requester through a valid/ready response handshake.
- Sits between the lab's operand sources (switch/sequencer logic) and the shared arithmetic unit.

Parameters:
SETTLE_CYCLES, 2, clock cycles operands are held before S/cout are sampled; legal range 1..15.

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-high reset
req_valid_0  input  1  requester 0 has an operation
req_ready_0  output  1  requester 0 operation accepted this cycle
A_0  input  4  requester 0 operand A (two's complement)
B_0  input  4  requester 0 operand B
sel_0  input  1  requester 0 op: 0 = A+B, 1 = A-B
req_valid_1, req_ready_1, A_1, B_1, sel_1: same as above, for requester 1
rsp_valid_0  output  1  result valid for requester 0
rsp_ready_0  input  1  requester 0 consumes result
rsp_valid_1  output  1  result valid for requester 1
rsp_ready_1  input  1  requester 1 consumes result
S  output  4  registered result
cout  output  1  registered carry-out of A + (sel ? ~B : B) + sel
ovf  output  1  registered signed overflow
busy  output  1  high whenever state != IDLE

Behaviour:
- Clock and reset: one clock, clk. rst is asynchronous, active-high.
- Reset values:
  - State IDLE; all outputs 0 (S=0, cout=0, ovf=0, busy=0, every ready and rsp_valid 0).
  - last_grant=1, so requester 0 wins the first tie.
- FSM states: IDLE, EXEC, RESP.
- Datapath instance: the arbiter instantiates the shared adder/subtractor. Its inputs come from internal operand registers op_A, op_B, op_sel, never directly from the request ports.
- IDLE:
  - grant = the requester whose req_valid is high.
  - If both are valid, grant = the requester not equal to last_grant.
  - req_ready_g = 1 combinationally, only for the granted requester and only in IDLE. req_ready never depends on rsp_ready.
  - On a valid&ready edge:
    - Capture A_g, B_g, sel_g into op regs.
    - Latch grant into gnt_reg.
    - cnt = SETTLE_CYCLES-1.
    - Go to EXEC.
- EXEC:
  - If cnt != 0: cnt decrements each cycle.
  - If cnt == 0: register S, cout and ovf from the datapath, then go to RESP.
  - ovf = (op_A[3] == Beff[3]) && (S[3] != op_A[3]), where Beff = op_sel ? ~op_B : op_B.
- RESP:
  - rsp_valid for gnt_reg is high; the other rsp_valid is low.
  - S, cout and ovf are held stable until rsp_ready for gnt_reg is high at a clock edge.
  - At that edge: last_grant = gnt_reg, go to IDLE.
  - rsp_ready of the non-granted requester is ignored.
- Latency: accept at edge k → rsp_valid high after edge k+SETTLE_CYCLES. Back-to-back throughput is one op per SETTLE_CYCLES+2 cycles minimum.
- Request changes while busy: request inputs may change freely while busy. Operands are isolated by op regs. A pending req_valid simply waits; requesters must hold req_valid and operands until req_ready.
- Arithmetic: 4-bit modular. Subtraction is A + ~B + 1. cout=1 on subtract means no borrow.
- Boundaries:
  - A single requester may be granted repeatedly when the other is idle.
  - Round-robin alternates strictly while both are continuously valid.
  - Assertion of rst in any state returns to IDLE at once and drops the in-flight op. No rsp_valid is produced for it.

Test Plan:
- After reset, req_0 only: A=2, B=3, sel=0 → req_ready_0 high in IDLE. With SETTLE_CYCLES=2, rsp_valid_0 is high 2 edges after accept, with S=5, cout=0, ovf=0.
- req_1 A=5, B=2, sel=1 → S=3, cout=1, ovf=0. Then A=2, B=5, sel=1 → S=4'b1101 (-3), cout=0, ovf=0.
- Overflow/carry on req_0:
  - A=5, B=6, sel=0 → S=4'b1011, cout=0, ovf=1.
  - A=10, B=12, sel=0 → S=4'b0110, cout=1, ovf=1.
  - A=-5, B=-2, sel=1 → S=4'b1101, cout=0, ovf=0.
- Both req_valid high from reset with distinct ops:
  - Grant order 0,1,0,1.
  - rsp_valid never high for both at once.
  - Each result matches its own operands.
- Hold rsp_ready_0 low for 5 cycles in RESP → S/cout/ovf stable, req_ready_1 stays 0 despite req_valid_1, busy=1. After rsp_ready_0 rises → IDLE, then req_1 granted.
- Assert rst during EXEC → outputs 0 and busy=0 immediately, no rsp_valid for the dropped op. The next request completes normally.
